// File: rtl/wb_stage_p.sv
// Writeback pipeline stage: M->W register, load extraction and result select.
// Optional retire counter on InstRetW is built when WB_RETIRE_CNT_EN is defined.
module wb_stage_p #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int CNTW = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [2:0]      LoadTypeM,
  input  logic [REGW-1:0] RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ImmExtM,
  input  logic            StallW,
  input  logic            FlushW,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic [REGW-1:0] RdW,
  output logic [XLEN-1:0] ResultW
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNTW-1:0] InstRetW
`endif
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic            validReg;
  logic            regWriteReg;
  logic [1:0]      resultSrcReg;
  logic [2:0]      loadTypeReg;
  logic [REGW-1:0] rdReg;
  logic [XLEN-1:0] aluResultReg;
  logic [XLEN-1:0] readDataReg;
  logic [XLEN-1:0] pcPlus4Reg;
  logic [XLEN-1:0] immExtReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      validReg     <= 1'b0;
      regWriteReg  <= 1'b0;
      resultSrcReg <= '0;
      loadTypeReg  <= '0;
      rdReg        <= '0;
      aluResultReg <= '0;
      readDataReg  <= '0;
      pcPlus4Reg   <= '0;
      immExtReg    <= '0;
    end else if (FlushW) begin
      // A flushed slot only loses its valid/write qualifiers; data is don't-care.
      validReg    <= 1'b0;
      regWriteReg <= 1'b0;
    end else if (!StallW) begin
      validReg     <= ValidM;
      regWriteReg  <= RegWriteM;
      resultSrcReg <= ResultSrcM;
      loadTypeReg  <= LoadTypeM;
      rdReg        <= RdM;
      aluResultReg <= ALUResultM;
      readDataReg  <= ReadDataM;
      pcPlus4Reg   <= PCPlus4M;
      immExtReg    <= ImmExtM;
    end
  end

  logic [OFFW-1:0] byteOff;
  logic [OFFW-1:0] halfOff;
  logic [OFFW-1:0] wordOff;
  logic [7:0]      byteLane;
  logic [15:0]     halfLane;
  logic [31:0]     wordLane;
  logic [XLEN-1:0] loadData;

  // Misaligned low address bits are masked off rather than trapped.
  always_comb begin
    byteOff  = aluResultReg[OFFW-1:0];
    halfOff  = byteOff & ~OFFW'(1);
    wordOff  = byteOff & ~OFFW'(3);
    byteLane = 8'(readDataReg >> {byteOff, 3'b000});
    halfLane = 16'(readDataReg >> {halfOff, 3'b000});
    wordLane = 32'(readDataReg >> {wordOff, 3'b000});
    loadData = readDataReg;
    case (loadTypeReg)
      3'b000:  loadData = XLEN'($signed(byteLane));
      3'b001:  loadData = XLEN'($signed(halfLane));
      3'b010:  loadData = XLEN'($signed(wordLane));
      3'b100:  loadData = XLEN'(byteLane);
      3'b101:  loadData = XLEN'(halfLane);
      3'b110:  loadData = (XLEN == 64) ? XLEN'(wordLane) : readDataReg;
      default: loadData = readDataReg;
    endcase
  end

  always_comb begin
    ResultW = aluResultReg;
    case (resultSrcReg)
      2'b00:   ResultW = aluResultReg;
      2'b01:   ResultW = loadData;
      2'b10:   ResultW = pcPlus4Reg;
      default: ResultW = immExtReg;
    endcase
  end

  assign ValidW    = validReg;
  assign RdW       = rdReg;
  assign RegWriteW = regWriteReg & validReg & (rdReg != '0);

`ifdef WB_RETIRE_CNT_EN
  logic [CNTW-1:0] instRetReg;

  // An instruction retires on the edge it leaves writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      instRetReg <= '0;
    end else if (validReg && !StallW) begin
      instRetReg <= instRetReg + CNTW'(1);
    end
  end

  assign InstRetW = instRetReg;
`endif

endmodule
